// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared encodings, FSM states and data helpers for cache_unit
// Purpose: access-size encodings, controller state enum, size-to-byte-count
//          and load extract/extend helpers used by cache_unit.
package cache_pkg;

  localparam logic [1:0] LIM_B = 2'b00;
  localparam logic [1:0] LIM_H = 2'b01;
  localparam logic [1:0] LIM_W = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_FILL   = 2'd2,
    ST_WRITE  = 2'd3
  } state_t;

  // Bytes moved by one access; the unused 2'b10 encoding behaves as a word.
  function automatic logic [2:0] lim_bytes(input logic [1:0] lim);
    case (lim)
      LIM_B:   lim_bytes = 3'd1;
      LIM_H:   lim_bytes = 3'd2;
      default: lim_bytes = 3'd4;
    endcase
  endfunction

  // Pick the addressed byte/half out of a little-endian word and extend it.
  function automatic logic [31:0] extract_ext(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [1:0]  lim,
                                              input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (lim)
      LIM_B:   extract_ext = {{24{sgn & b[7]}}, b};
      LIM_H:   extract_ext = {{16{sgn & h[15]}}, h};
      default: extract_ext = word;
    endcase
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// rtl/cache_tag_store.sv - per-line valid/tag/data arrays with combinational hit
// Purpose: storage for the direct-mapped cache; valid bits clear asynchronously.
// Ports: clk, rst_n          - clock, async active-low reset (clears valid bits)
//        rd_idx, rd_tag      - lookup index/tag; hit, rd_data combinational result
//        wr_en, wr_idx, wr_tag, wr_be, wr_data - line write (sets valid, tag, enabled bytes)
module cache_tag_store #(
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             hit,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [3:0]       wr_be,
  input  logic [31:0]      wr_data
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tag/data need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) data_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data = data_q[rd_idx];

endmodule

// File: rtl/cache_unit.sv
// rtl/cache_unit.sv - direct-mapped write-through cache with byte-wide memory port
// Purpose: serves byte/half/word loads and stores; misses and all stores become
//          single-byte memory transactions. Macro CACHE_LOOKUP_EN enables the
//          tag/data arrays; without it every load is a 4-byte fill.
// Ports: CLK, RST (async active-low)
//        CPU side: ADDR, DIN, WE, RREQ, LIM, SIGNED in; DOUT, RDY out
//        Memory side: MADDR, MDOUT, MRE, MWE out; MDIN, MRDY in
module cache_unit
  import cache_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       DIN,
  input  logic              WE,
  input  logic              RREQ,
  input  logic [1:0]        LIM,
  input  logic              SIGNED,
  output logic [31:0]       DOUT,
  output logic              RDY,
  output logic [ADDR_W-1:0] MADDR,
  output logic [7:0]        MDOUT,
  input  logic [7:0]        MDIN,
  output logic              MRE,
  output logic              MWE,
  input  logic              MRDY
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, maddr_q, maddr_d;
  logic [31:0]       din_q, din_d, dout_q, dout_d, fill_q, fill_d;
  logic [1:0]        lim_q, lim_d, cnt_q, cnt_d;
  logic              sgn_q, sgn_d, we_q, we_d, mre_q, mre_d, mwe_q, mwe_d;
  logic [7:0]        mdout_q, mdout_d;

  logic [1:0]  off, in_mask;
  logic [2:0]  in_bytes;
  logic        last_byte, lk_hit;
  logic [31:0] lk_data, fill_word;
  logic        c_we;
  logic [3:0]  c_be;
  logic [31:0] c_wdata;

  assign off       = addr_q[1:0];
  assign in_bytes  = lim_bytes(LIM);
  assign in_mask   = in_bytes[1:0] - 2'd1;
  assign last_byte = ({1'b0, cnt_q} == (lim_bytes(lim_q) - 3'd1));
  assign fill_word = {MDIN, fill_q[23:0]};

`ifdef CACHE_LOOKUP_EN
  cache_tag_store #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_store (
    .clk     (CLK),
    .rst_n   (RST),
    .rd_idx  (addr_q[2 +: IDX_W]),
    .rd_tag  (addr_q[ADDR_W-1 -: TAG_W]),
    .hit     (lk_hit),
    .rd_data (lk_data),
    .wr_en   (c_we),
    .wr_idx  (addr_q[2 +: IDX_W]),
    .wr_tag  (addr_q[ADDR_W-1 -: TAG_W]),
    .wr_be   (c_be),
    .wr_data (c_wdata)
  );
`else
  logic unused_store;
  assign lk_hit       = 1'b0;
  assign lk_data      = '0;
  assign unused_store = ^{c_we, c_be, c_wdata};
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    lim_d   = lim_q;
    sgn_d   = sgn_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    fill_d  = fill_q;
    maddr_d = maddr_q;
    mdout_d = mdout_q;
    mre_d   = mre_q;
    mwe_d   = mwe_q;
    c_we    = 1'b0;
    c_be    = 4'h0;
    c_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (WE || RREQ) begin
          addr_d  = {ADDR[ADDR_W-1:2], ADDR[1:0] & ~in_mask};
          din_d   = DIN;
          lim_d   = LIM;
          sgn_d   = SIGNED;
          we_d    = WE;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        cnt_d = 2'd0;
        if (we_q) begin
          // Write-through: merge into a hit line now, never allocate on miss.
          c_we    = lk_hit;
          c_wdata = din_q << {off, 3'b000};
          case (lim_q)
            LIM_B:   c_be = 4'b0001 << off;
            LIM_H:   c_be = 4'b0011 << off;
            default: c_be = 4'b1111;
          endcase
          mwe_d   = 1'b1;
          maddr_d = addr_q;
          mdout_d = din_q[7:0];
          state_d = ST_WRITE;
        end else if (lk_hit) begin
          dout_d  = extract_ext(lk_data, off, lim_q, sgn_q);
          state_d = ST_IDLE;
        end else begin
          mre_d   = 1'b1;
          maddr_d = {addr_q[ADDR_W-1:2], 2'b00};
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (!mre_q) begin
          mre_d   = 1'b1;
          maddr_d = {addr_q[ADDR_W-1:2], cnt_q};
        end else if (MRDY) begin
          mre_d = 1'b0;
          fill_d[{cnt_q, 3'b000} +: 8] = MDIN;
          if (cnt_q == 2'd3) begin
            c_we    = 1'b1;
            c_be    = 4'hF;
            c_wdata = fill_word;
            dout_d  = extract_ext(fill_word, off, lim_q, sgn_q);
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      ST_WRITE: begin
        if (!mwe_q) begin
          mwe_d   = 1'b1;
          maddr_d = {addr_q[ADDR_W-1:2], off + cnt_q};
          mdout_d = din_q[{cnt_q, 3'b000} +: 8];
        end else if (MRDY) begin
          mwe_d = 1'b0;
          if (last_byte) state_d = ST_IDLE;
          else           cnt_d   = cnt_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      lim_q   <= LIM_W;
      sgn_q   <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= 2'd0;
      dout_q  <= '0;
      fill_q  <= '0;
      maddr_q <= '0;
      mdout_q <= '0;
      mre_q   <= 1'b0;
      mwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      lim_q   <= lim_d;
      sgn_q   <= sgn_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      fill_q  <= fill_d;
      maddr_q <= maddr_d;
      mdout_q <= mdout_d;
      mre_q   <= mre_d;
      mwe_q   <= mwe_d;
    end
  end

  assign RDY   = (state_q == ST_IDLE);
  assign DOUT  = dout_q;
  assign MADDR = maddr_q;
  assign MDOUT = mdout_q;
  assign MRE   = mre_q;
  assign MWE   = mwe_q;

endmodule
